// File: rtl/gpio_ctrl.sv
// gpio_ctrl: parametrised GPIO controller for the tinyriscv peripheral bus.
//   NUM_IO pins, each with direction, atomic set/clear/toggle of output data,
//   a SYNC_STAGES input synchroniser and rising/falling edge interrupts that
//   OR together into one level interrupt.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_i, we_i         single-cycle bus request, 1=write
//   addr_i, data_i      byte address (only [5:2] decoded), write data
//   data_o, ack_o       registered read data and one-cycle acknowledge
//   io_pin_i            raw asynchronous pad inputs
//   io_out_o, io_oe_o   pad output value and output enable
//   irq_o               level interrupt, OR of pending flags

// Per-pin input path: synchroniser, edge detector and pending flag.
module gpio_pin #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    input  logic rise_en,
    input  logic fall_en,
    input  logic pend_clr,
    output logic sync_o,
    output logic pend_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pend_q;
    logic                   hit;

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign pend_o = pend_q;

    // Enables gate the edge at detection time, so an edge seen while
    // disabled is gone for good.
    assign hit = (sync_o & ~prev_q & rise_en) | (~sync_o & prev_q & fall_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q <= sync_o;
            // New edge beats a same-cycle W1C clear.
            pend_q <= (pend_q & ~pend_clr) | hit;
        end
    end
endmodule

module gpio_ctrl #(
    parameter int NUM_IO      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              ack_o,
    input  logic [NUM_IO-1:0] io_pin_i,
    output logic [NUM_IO-1:0] io_out_o,
    output logic [NUM_IO-1:0] io_oe_o,
    output logic              irq_o
);
    localparam logic [3:0] REG_DIR  = 4'h0;
    localparam logic [3:0] REG_OUT  = 4'h1;
    localparam logic [3:0] REG_IN   = 4'h2;
    localparam logic [3:0] REG_SET  = 4'h3;
    localparam logic [3:0] REG_CLR  = 4'h4;
    localparam logic [3:0] REG_TGL  = 4'h5;
    localparam logic [3:0] REG_RISE = 4'h6;
    localparam logic [3:0] REG_FALL = 4'h7;
    localparam logic [3:0] REG_PEND = 4'h8;

    logic [NUM_IO-1:0] dir_q, out_q, rise_en_q, fall_en_q;
    logic [NUM_IO-1:0] sync, pend, pend_clr;
    logic [NUM_IO-1:0] wdata;
    logic [3:0]        sel;
    logic              wr;
    logic [31:0]       rdata;
    logic              unused_bits;

    assign sel   = addr_i[5:2];
    assign wr    = req_i & we_i;
    assign wdata = data_i[NUM_IO-1:0];
    assign unused_bits = ^{addr_i[31:6], addr_i[1:0], data_i};

    assign pend_clr = (wr && sel == REG_PEND) ? wdata : '0;

    gpio_pin #(.SYNC_STAGES(SYNC_STAGES)) u_pin [NUM_IO-1:0] (
        .clk      (clk),
        .rst      (rst),
        .pin_i    (io_pin_i),
        .rise_en  (rise_en_q),
        .fall_en  (fall_en_q),
        .pend_clr (pend_clr),
        .sync_o   (sync),
        .pend_o   (pend)
    );

    assign io_out_o = out_q;
    assign io_oe_o  = dir_q;
    assign irq_o    = |pend;

    // Write-only and unmapped offsets read as zero.
    always_comb begin
        rdata = '0;
        case (sel)
            REG_DIR:  rdata[NUM_IO-1:0] = dir_q;
            REG_OUT:  rdata[NUM_IO-1:0] = out_q;
            REG_IN:   rdata[NUM_IO-1:0] = sync;
            REG_RISE: rdata[NUM_IO-1:0] = rise_en_q;
            REG_FALL: rdata[NUM_IO-1:0] = fall_en_q;
            REG_PEND: rdata[NUM_IO-1:0] = pend;
            default:  rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            data_o    <= '0;
            ack_o     <= 1'b0;
        end else begin
            ack_o <= req_i;
            // data_o only moves on reads; it holds across write acks and idle.
            if (req_i && !we_i)
                data_o <= rdata;
            if (wr) begin
                case (sel)
                    REG_DIR:  dir_q     <= wdata;
                    REG_OUT:  out_q     <= wdata;
                    REG_SET:  out_q     <= out_q | wdata;
                    REG_CLR:  out_q     <= out_q & ~wdata;
                    REG_TGL:  out_q     <= out_q ^ wdata;
                    REG_RISE: rise_en_q <= wdata;
                    REG_FALL: fall_en_q <= wdata;
                    default:  ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gpio_ctrl.sv
module tb_gpio_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, req8 = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdat = '0;
    logic [31:0] data_o, data_o8;
    logic        ack_o, ack_o8, irq_o, irq_o8;
    logic [15:0] pin = '0, io_out, io_oe;
    logic [7:0]  pin8 = '0, io_out8, io_oe8;

    int cyc = 0;
    int tests_run = 0;
    int fails = 0;

    typedef struct {
        logic        rd;
        logic [31:0] d;
        int          cyc;
    } exp_t;
    exp_t q16[$];
    exp_t q8[$];
    exp_t e16, e8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    gpio_ctrl #(.NUM_IO(16), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .data_i(wdat), .data_o(data_o), .ack_o(ack_o), .io_pin_i(pin),
        .io_out_o(io_out), .io_oe_o(io_oe), .irq_o(irq_o)
    );

    gpio_ctrl #(.NUM_IO(8), .SYNC_STAGES(2)) u_dut8 (
        .clk(clk), .rst(rst), .req_i(req8), .we_i(we), .addr_i(addr),
        .data_i(wdat), .data_o(data_o8), .ack_o(ack_o8), .io_pin_i(pin8),
        .io_out_o(io_out8), .io_oe_o(io_oe8), .irq_o(irq_o8)
    );

    // Scoreboard: each ack pops one expected transaction.
    always @(negedge clk) begin
        if (!rst && ack_o) begin
            tests_run++;
            if (q16.size() == 0) begin
                fails++;
                $display("FAIL ack16_unexpected cycle=%0d", cyc);
            end else begin
                e16 = q16.pop_front();
                if (cyc != e16.cyc + 1) begin
                    fails++;
                    $display("FAIL ack16_latency got cycle %0d want %0d", cyc, e16.cyc + 1);
                end
                if (e16.rd && data_o !== e16.d) begin
                    fails++;
                    $display("FAIL rd16_data got %h want %h", data_o, e16.d);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ack_o8) begin
            tests_run++;
            if (q8.size() == 0) begin
                fails++;
                $display("FAIL ack8_unexpected cycle=%0d", cyc);
            end else begin
                e8 = q8.pop_front();
                if (cyc != e8.cyc + 1) begin
                    fails++;
                    $display("FAIL ack8_latency got cycle %0d want %0d", cyc, e8.cyc + 1);
                end
                if (e8.rd && data_o8 !== e8.d) begin
                    fails++;
                    $display("FAIL rd8_data got %h want %h", data_o8, e8.d);
                end
            end
        end
    end

    // One bus transaction: starts #1 after an edge, ends #1 after the next.
    task automatic bus(input bit s8, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp);
        exp_t e;
        e.rd = !w; e.d = exp; e.cyc = cyc;
        if (s8) q8.push_back(e); else q16.push_back(e);
        we = w; addr = a; wdat = d;
        if (s8) req8 = 1'b1; else req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; req8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pin = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (io_oe !== 16'h0)  begin fails++; $display("FAIL rst_oe got %h want 0", io_oe); end
        tests_run++; if (io_out !== 16'h0) begin fails++; $display("FAIL rst_out got %h want 0", io_out); end
        tests_run++; if (irq_o !== 1'b0)   begin fails++; $display("FAIL rst_irq got %b want 0", irq_o); end
        tests_run++; if (ack_o !== 1'b0 || data_o !== 32'h0) begin fails++; $display("FAIL rst_bus got ack=%b data=%h want 0", ack_o, data_o); end
        tests_run++; if (io_oe8 !== 8'h0)  begin fails++; $display("FAIL rst_oe8 got %h want 0", io_oe8); end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus(0, 0, 32'h08, 0, 32'h0000FFFF);
        bus(0, 0, 32'h00, 0, 32'h0);
    endtask

    task automatic test_atomic();
        bus(0, 1, 32'h00, 32'hFFFF, 0);
        tests_run++; if (io_oe !== 16'hFFFF) begin fails++; $display("FAIL dir_oe got %h want ffff", io_oe); end
        bus(0, 1, 32'h04, 32'h00F0, 0);
        bus(0, 1, 32'h0C, 32'h000F, 0);
        tests_run++; if (io_out !== 16'h00FF) begin fails++; $display("FAIL set got %h want 00ff", io_out); end
        bus(0, 1, 32'h10, 32'h00F0, 0);
        tests_run++; if (io_out !== 16'h000F) begin fails++; $display("FAIL clr got %h want 000f", io_out); end
        bus(0, 1, 32'h14, 32'hFFFF, 0);
        tests_run++; if (io_out !== 16'hFFF0) begin fails++; $display("FAIL tgl got %h want fff0", io_out); end
        bus(0, 0, 32'h0C, 0, 32'h0);
        bus(0, 0, 32'h10, 0, 32'h0);
        bus(0, 0, 32'h04, 0, 32'h0000FFF0);
    endtask

    task automatic test_back_to_back();
        bus(0, 1, 32'h04, 32'h1234, 0);
        bus(0, 0, 32'h04, 0, 32'h1234);
        bus(0, 1, 32'h14, 32'h00FF, 0);
        bus(0, 0, 32'h04, 0, 32'h12CB);
        bus(0, 0, 32'hABCD_0007, 0, 32'h12CB);
        bus(0, 0, 32'h00, 0, 32'hFFFF);
    endtask

    task automatic test_edge_irq();
        pin = 16'h0;
        repeat (4) @(posedge clk);
        #1;
        bus(0, 1, 32'h20, 32'hFFFF, 0);
        bus(0, 1, 32'h18, 32'h0001, 0);
        bus(0, 0, 32'h20, 0, 32'h0);
        pin[0] = 1'b1;
        @(posedge clk); #1;
        bus(0, 0, 32'h08, 0, 32'h0);
        tests_run++; if (irq_o !== 1'b0) begin fails++; $display("FAIL irq_early got %b want 0", irq_o); end
        bus(0, 0, 32'h08, 0, 32'h1);
        tests_run++; if (irq_o !== 1'b1) begin fails++; $display("FAIL irq_rise got %b want 1", irq_o); end
        bus(0, 0, 32'h20, 0, 32'h1);
        bus(0, 1, 32'h20, 32'h1, 0);
        pin[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        tests_run++; if (irq_o !== 1'b0) begin fails++; $display("FAIL irq_fall_dis got %b want 0", irq_o); end
        bus(0, 0, 32'h20, 0, 32'h0);
    endtask

    task automatic test_w1c_race();
        bus(0, 1, 32'h18, 32'h0008, 0);
        pin[3] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        tests_run++; if (irq_o !== 1'b1) begin fails++; $display("FAIL race_pre got %b want 1", irq_o); end
        pin[3] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        pin[3] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus(0, 1, 32'h20, 32'h0008, 0);
        tests_run++; if (irq_o !== 1'b1) begin fails++; $display("FAIL race_set_wins got %b want 1", irq_o); end
        bus(0, 0, 32'h20, 0, 32'h8);
        bus(0, 1, 32'h20, 32'h0008, 0);
        tests_run++; if (irq_o !== 1'b0) begin fails++; $display("FAIL w1c_clear got %b want 0", irq_o); end
        bus(0, 0, 32'h20, 0, 32'h0);
        // Edge on a disabled pin must not surface after enabling it.
        pin[5] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        bus(0, 1, 32'h18, 32'h0028, 0);
        repeat (3) @(posedge clk);
        #1;
        bus(0, 0, 32'h20, 0, 32'h0);
    endtask

    task automatic test_width();
        bus(1, 1, 32'h00, 32'hFFFF_FFFF, 0);
        tests_run++; if (io_oe8 !== 8'hFF) begin fails++; $display("FAIL w8_oe got %h want ff", io_oe8); end
        bus(1, 0, 32'h00, 0, 32'h0000_00FF);
        bus(1, 0, 32'h30, 0, 32'h0);
        bus(1, 1, 32'h3C, 32'hFFFF_FFFF, 0);
        bus(1, 0, 32'h04, 0, 32'h0);
        bus(1, 0, 32'h18, 0, 32'h0);
        bus(1, 0, 32'h1C, 0, 32'h0);
        bus(1, 0, 32'h00, 0, 32'h0000_00FF);
        bus(0, 0, 32'h30, 0, 32'h0);
    endtask

    task automatic test_reset_mid();
        pin[3] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        pin[3] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        tests_run++; if (irq_o !== 1'b1) begin fails++; $display("FAIL mid_pre_irq got %b want 1", irq_o); end
        we = 1'b1; addr = 32'h04; wdat = 32'hA5; req = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        tests_run++; if (ack_o !== 1'b0)  begin fails++; $display("FAIL mid_ack got %b want 0", ack_o); end
        tests_run++; if (io_out !== 16'h0) begin fails++; $display("FAIL mid_out got %h want 0", io_out); end
        tests_run++; if (irq_o !== 1'b0)  begin fails++; $display("FAIL mid_irq got %b want 0", irq_o); end
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++; if (ack_o !== 1'b0)  begin fails++; $display("FAIL mid_late_ack got %b want 0", ack_o); end
        bus(0, 0, 32'h04, 0, 32'h0);
        bus(0, 0, 32'h20, 0, 32'h0);
        bus(0, 0, 32'h18, 0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_atomic();
        test_back_to_back();
        test_edge_irq();
        test_w1c_race();
        test_width();
        test_reset_mid();
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (q16.size() != 0 || q8.size() != 0) begin
            fails++;
            $display("FAIL missing_ack got %0d/%0d outstanding want 0", q16.size(), q8.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
